// File: rtl/rv32v_element_sequencer.sv
// Execute-side vector element sequencer: walks the element index space two
// elements per cycle (even/odd lanes) between decode_done and done.
module rv32v_element_sequencer #(
    parameter int IDX_W = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             decode_done,
    input  logic [31:0]      vl,
    input  logic [31:0]      vstart,
    input  logic             stall,
    input  logic             flush,
    output logic             busy,
    output logic             elem_valid,
    output logic [IDX_W-1:0] woffset0,
    output logic [IDX_W-1:0] woffset1,
    output logic             lane_ena0,
    output logic             lane_ena1,
    output logic             last,
    output logic             done,
    output logic [31:0]      vstart_next
);

    localparam logic [31:0]    VLMAX   = 32'((1 << IDX_W) - 1);
    localparam logic [IDX_W:0] VLMAX_I = VLMAX[IDX_W:0];
    localparam logic [IDX_W:0] ONE     = 1;
    localparam logic [IDX_W:0] TWO     = 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [IDX_W:0] ptr, vl_eff, vs;
    logic           accepted;

    logic [IDX_W:0] vl_in, vs_in, cur_vl, cur_vs, np, np1, np2;
    logic           start_empty, n_ena0, n_ena1, n_last;

    // Index math is one bit wider than the offsets so ptr+2 never wraps.
    // In IDLE the limits come straight from the inputs being latched.
    always_comb begin
        vl_in       = (vl > VLMAX) ? VLMAX_I : vl[IDX_W:0];
        vs_in       = vstart[IDX_W:0];
        start_empty = (vl_in == '0) || (vstart >= {{(31-IDX_W){1'b0}}, vl_in});
        cur_vl      = (state == IDLE) ? vl_in : vl_eff;
        cur_vs      = (state == IDLE) ? vs_in : vs;
        np          = (state == IDLE) ? {vs_in[IDX_W:1], 1'b0} : ptr + TWO;
        np1         = np + ONE;
        np2         = np + TWO;
        n_ena0      = (np >= cur_vs) && (np < cur_vl);
        n_ena1      = (np1 >= cur_vs) && (np1 < cur_vl);
        n_last      = (np2 >= cur_vl);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            ptr         <= '0;
            vl_eff      <= '0;
            vs          <= '0;
            accepted    <= 1'b0;
            busy        <= 1'b0;
            elem_valid  <= 1'b0;
            woffset0    <= '0;
            woffset1    <= '0;
            lane_ena0   <= 1'b0;
            lane_ena1   <= 1'b0;
            last        <= 1'b0;
            done        <= 1'b0;
            vstart_next <= '0;
        end else if (flush) begin
            state      <= IDLE;
            busy       <= 1'b0;
            elem_valid <= 1'b0;
            lane_ena0  <= 1'b0;
            lane_ena1  <= 1'b0;
            last       <= 1'b0;
            done       <= 1'b0;
            if (state != IDLE)
                vstart_next <= {{(31-IDX_W){1'b0}}, (accepted ? ptr : vs)};
        end else begin
            case (state)
                IDLE: if (decode_done) begin
                    vl_eff      <= vl_in;
                    vs          <= vs_in;
                    accepted    <= 1'b0;
                    vstart_next <= '0;
                    busy        <= 1'b1;
                    if (start_empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state      <= RUN;
                        ptr        <= np;
                        elem_valid <= 1'b1;
                        woffset0   <= np[IDX_W-1:0];
                        woffset1   <= np1[IDX_W-1:0];
                        lane_ena0  <= n_ena0;
                        lane_ena1  <= n_ena1;
                        last       <= n_last;
                    end
                end
                RUN: if (!stall) begin
                    accepted <= 1'b1;
                    ptr      <= np;
                    if (last) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        elem_valid <= 1'b0;
                        lane_ena0  <= 1'b0;
                        lane_ena1  <= 1'b0;
                        last       <= 1'b0;
                    end else begin
                        woffset0  <= np[IDX_W-1:0];
                        woffset1  <= np1[IDX_W-1:0];
                        lane_ena0 <= n_ena0;
                        lane_ena1 <= n_ena1;
                        last      <= n_last;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32v_element_sequencer.sv
// Self-checking bench for rv32v_element_sequencer: directed scenarios plus
// randomized instructions compared against an arithmetic pair-sequence model.
module tb_rv32v_element_sequencer;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        decode_done = 1'b0;
    logic [31:0] vl = '0;
    logic [31:0] vstart = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        busy, elem_valid, lane_ena0, lane_ena1, last, done;
    logic [7:0]  woffset0, woffset1;
    logic [31:0] vstart_next;

    int checks = 0;
    int errors = 0;

    rv32v_element_sequencer #(.IDX_W(8)) dut (
        .CLK(CLK), .nRST(nRST), .decode_done(decode_done), .vl(vl),
        .vstart(vstart), .stall(stall), .flush(flush), .busy(busy),
        .elem_valid(elem_valid), .woffset0(woffset0), .woffset1(woffset1),
        .lane_ena0(lane_ena0), .lane_ena1(lane_ena1), .last(last),
        .done(done), .vstart_next(vstart_next)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Issue one instruction and follow it to completion. Expected pairs come
    // from the body rule: pairs start at the even index at or below vstart and
    // continue until the pair containing vl_eff-1 has been accepted.
    task automatic run_instr(input logic [31:0] v, input logic [31:0] s,
                             input int pct, input int sidx, input int sn);
        int vle, si, p0, n, k, cyc, stalls, sc, p;
        bit empty, st;
        logic [21:0] act, exp;
        vle   = (v > 32'd255) ? 255 : int'(v);
        empty = (vle == 0) || (s >= 32'(vle));
        si = 0; p0 = 0; n = 0;
        if (!empty) begin
            si = int'(s);
            p0 = (si / 2) * 2;
            n  = (vle - p0 + 1) / 2;
        end
        vl = v; vstart = s; decode_done = 1'b1;
        step();
        decode_done = 1'b0;
        cyc = 1; k = 0; stalls = 0; sc = 0;
        checks++;
        if (vstart_next !== 32'd0) begin
            errors++;
            $display("FAIL vstart_clear vl=%0d vs=%0d got %0d want 0", v, s, vstart_next);
        end
        while (k < n && cyc < 3000) begin
            p   = p0 + 2 * k;
            act = {elem_valid, woffset0, woffset1, lane_ena0, lane_ena1, last, done, busy};
            exp = {1'b1, 8'(p), 8'(p + 1), (p >= si) && (p < vle),
                   (p + 1 >= si) && (p + 1 < vle), (p + 2 >= vle), 1'b0, 1'b1};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL pair vl=%0d vs=%0d k=%0d got %h want %h", v, s, k, act, exp);
            end
            st = (k == sidx && sc < sn) || ($urandom_range(99) < pct);
            if (k == sidx && sc < sn) sc++;
            stall = st;
            step();
            stall = 1'b0;
            cyc++;
            if (st) stalls++;
            else k++;
        end
        checks++;
        if ({elem_valid, lane_ena0, lane_ena1, last, done, busy} !== 6'b000011) begin
            errors++;
            $display("FAIL done_state vl=%0d vs=%0d got %b want 000011", v, s,
                     {elem_valid, lane_ena0, lane_ena1, last, done, busy});
        end
        checks++;
        if (cyc != 1 + n + stalls) begin
            errors++;
            $display("FAIL done_time vl=%0d vs=%0d got T+%0d want T+%0d", v, s, cyc, 1 + n + stalls);
        end
        step();
        checks++;
        if ({elem_valid, done, busy} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after vl=%0d vs=%0d got %b want 000", v, s, {elem_valid, done, busy});
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        step(); step();
        checks++;
        if ({busy, elem_valid, woffset0, woffset1, lane_ena0, lane_ena1, last, done, vstart_next} !== '0) begin
            errors++;
            $display("FAIL reset got busy=%b ev=%b w0=%0d w1=%0d done=%b vsn=%0d want all 0",
                     busy, elem_valid, woffset0, woffset1, done, vstart_next);
        end
        nRST = 1'b1;
        step();
    endtask

    task automatic test_directed();
        run_instr(32'd5, 32'd0, 0, -1, 0);
        run_instr(32'd6, 32'd3, 0, -1, 0);
        run_instr(32'd0, 32'd0, 0, -1, 0);
        run_instr(32'd4, 32'd4, 0, -1, 0);
        run_instr(32'd8, 32'd0, 0, 1, 3);
        run_instr(32'd300, 32'd0, 0, -1, 0);
        run_instr(32'd300, 32'd253, 0, -1, 0);
        run_instr(32'd7, 32'd1000, 0, -1, 0);
    endtask

    task automatic test_flush();
        vl = 32'd16; vstart = 32'd0; decode_done = 1'b1;
        step();
        decode_done = 1'b0;
        step(); step(); step();
        checks++;
        if ({elem_valid, woffset0} !== {1'b1, 8'd6}) begin
            errors++;
            $display("FAIL flush_setup got ev=%b w0=%0d want 1/6", elem_valid, woffset0);
        end
        flush = 1'b1; decode_done = 1'b1; vl = 32'd4;
        step();
        flush = 1'b0; decode_done = 1'b0;
        checks++;
        if ({elem_valid, done, busy, vstart_next} !== {3'b000, 32'd6}) begin
            errors++;
            $display("FAIL flush_mid got ev=%b done=%b busy=%b vsn=%0d want 0/0/0/6",
                     elem_valid, done, busy, vstart_next);
        end
        step();
        checks++;
        if ({elem_valid, done, busy} !== 3'b000) begin
            errors++;
            $display("FAIL flush_drop got %b want 000", {elem_valid, done, busy});
        end
        vl = 32'd10; vstart = 32'd3; decode_done = 1'b1;
        step();
        decode_done = 1'b0; flush = 1'b1; stall = 1'b1;
        step();
        flush = 1'b0; stall = 1'b0;
        checks++;
        if ({elem_valid, busy, vstart_next} !== {2'b00, 32'd3}) begin
            errors++;
            $display("FAIL flush_first got ev=%b busy=%b vsn=%0d want 0/0/3", elem_valid, busy, vstart_next);
        end
        step();
    endtask

    task automatic test_back_to_back();
        vl = 32'd0; vstart = 32'd0; decode_done = 1'b1;
        step();
        vl = 32'd10;
        checks++;
        if ({done, busy} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_done got %b want 11", {done, busy});
        end
        step();
        decode_done = 1'b0;
        checks++;
        if ({elem_valid, done, busy} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_ignored got %b want 000", {elem_valid, done, busy});
        end
        run_instr(32'd3, 32'd0, 0, -1, 0);
        run_instr(32'd9, 32'd2, 0, -1, 0);
    endtask

    task automatic test_random();
        logic [31:0] v, s;
        for (int i = 0; i < 40; i++) begin
            v = ($urandom_range(9) == 0) ? 32'($urandom_range(400)) : 32'($urandom_range(40));
            s = 32'($urandom_range(int'(v > 32'd300 ? 32'd300 : v) + 2));
            run_instr(v, s, 30, -1, 0);
        end
    endtask

    task automatic test_reset_mid();
        vl = 32'd300; vstart = 32'd0; decode_done = 1'b1;
        step();
        decode_done = 1'b0;
        step(); step(); step();
        nRST = 1'b0;
        #1;
        checks++;
        if ({busy, elem_valid, woffset0, woffset1, lane_ena0, lane_ena1, last, done, vstart_next} !== '0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b ev=%b w0=%0d w1=%0d want all 0",
                     busy, elem_valid, woffset0, woffset1);
        end
        #2 nRST = 1'b1;
        step(); step();
        checks++;
        if ({elem_valid, done, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_idle got %b want 000", {elem_valid, done, busy});
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
